// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the two-requester RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_MEM_DEPTH  = 8;
  localparam int unsigned DEF_MEM_WIDTH  = 16;
  localparam int unsigned NUM_REQ        = 2;

  typedef enum logic {
    INIT,
    ARB
  } state_e;

  // Travels alongside each accepted request until its response is issued.
  typedef struct packed {
    logic id;
    logic err;
    logic is_read;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  logic rr_q, rr_d;

  // Single requester wins outright; on a tie the pointer decides.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
  end

  // After any grant, priority moves to the other requester.
  always_comb begin
    rr_d = rr_q;
    if (grant[0])      rr_d = 1'b1;
    else if (grant[1]) rr_d = 1'b0;
  end

  // Pointer register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Clears the RAM after reset, then shares it between two requesters with
// round-robin arbitration and in-order, fixed-latency responses.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned          MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned          MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [NUM_REQ-1:0]            ReqWrEn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]  ReqWrData,
  output logic [NUM_REQ-1:0]            RspValid,
  output logic [MEM_WIDTH-1:0]          RspRdData,
  output logic                          RspErr,
  output logic                          InitDone,
  output logic                          WrEn,
  output logic                          RdEn,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic [MEM_WIDTH-1:0]          WrData,
  input  logic [MEM_WIDTH-1:0]          RdData
);

  localparam int unsigned CntW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  t1_vld_q, t1_vld_d, t2_vld_q;
  tag_t                  t1_q, t1_d, t2_q;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [MEM_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    arb_req, grant;
  logic                  sel, sel_we, in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_WIDTH-1:0]  sel_wdata;

  // Requesters are ignored entirely until the clear has finished.
  assign arb_req = (state_q == ARB) ? ReqValid : '0;

  rr_arbiter2 u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req   (arb_req),
    .grant (grant)
  );

  // Mux the granted requester's command.
  assign sel       = grant[1];
  assign sel_we    = ReqWrEn[sel];
  assign sel_addr  = sel ? ReqAddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : ReqAddr[ADDR_WIDTH-1:0];
  assign sel_wdata = sel ? ReqWrData[2*MEM_WIDTH-1:MEM_WIDTH] : ReqWrData[MEM_WIDTH-1:0];
  assign in_range  = {1'b0, sel_addr} < DepthLim;

  // Next-state: FSM, clear counter, RAM command and tag/response pipeline.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    t1_vld_d = 1'b0;
    t1_d     = '0;

    unique case (state_q)
      INIT: begin
        wr_en_d = 1'b1;
        addr_d  = ADDR_WIDTH'(cnt_q);
        wdata_d = INIT_VALUE;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MEM_DEPTH - 1)) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      ARB: begin
        if (|grant) begin
          t1_vld_d = 1'b1;
          t1_d     = '{id: sel, err: !in_range, is_read: !sel_we};
          // Out-of-range requests still take a pipeline slot but never reach the RAM.
          if (in_range) begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            wr_en_d = sel_we;
            rd_en_d = !sel_we;
          end
        end
      end
      default: state_d = INIT;
    endcase

    rsp_valid_d = t2_vld_q ? (NUM_REQ'(1) << t2_q.id) : '0;
    rsp_err_d   = t2_vld_q && t2_q.err;
    rsp_data_d  = (t2_vld_q && t2_q.is_read && !t2_q.err) ? RdData : '0;
  end

  // State registers; reset discards any in-flight tags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      t1_vld_q    <= 1'b0;
      t1_q        <= '0;
      t2_vld_q    <= 1'b0;
      t2_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      t1_vld_q    <= t1_vld_d;
      t1_q        <= t1_d;
      t2_vld_q    <= t1_vld_q;
      t2_q        <= t1_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ReqReady  = grant;
  assign InitDone  = (state_q == ARB);
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign address   = addr_q;
  assign WrData    = wdata_q;
  assign RspValid  = rsp_valid_q;
  assign RspRdData = rsp_data_q;
  assign RspErr    = rsp_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  ReqValid = '0;
  logic [1:0]  ReqReady;
  logic [1:0]  ReqWrEn = '0;
  logic [7:0]  ReqAddr = '0;
  logic [31:0] ReqWrData = '0;
  logic [1:0]  RspValid;
  logic [15:0] RspRdData;
  logic        RspErr;
  logic        InitDone;
  logic        WrEn, RdEn;
  logic [3:0]  address;
  logic [15:0] WrData;
  logic [15:0] RdData;

  ram_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrEn   (ReqWrEn),
    .ReqAddr   (ReqAddr),
    .ReqWrData (ReqWrData),
    .RspValid  (RspValid),
    .RspRdData (RspRdData),
    .RspErr    (RspErr),
    .InitDone  (InitDone),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .address   (address),
    .WrData    (WrData),
    .RdData    (RdData)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ram_cmds = 0;
  int init_cnt = 0;
  logic [7:0] init_mask = '0;

  typedef struct {
    int          id;
    bit          err;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // RAM model: garbage at power-up so the clear is observable.
  logic [15:0] mem [0:15];
  bit          mem_primed = 1'b0;
  always @(posedge CLK) begin
    if (!mem_primed) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hDEAD;
      mem_primed <= 1'b1;
    end else begin
      if (WrEn) mem[address] <= WrData;
      if (RdEn) RdData <= mem[address];
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM-side monitor: command count, range, and clear coverage.
  always @(posedge CLK) begin
    if (RST) begin
      init_mask = '0;
      init_cnt  = 0;
    end else begin
      if (WrEn || RdEn) begin
        ram_cmds++;
        if (address >= 4'd8) begin
          checks++;
          errors++;
          $display("FAIL ram_addr_range: got address=%0d, want < 8", address);
        end
      end
      if (WrEn && WrData == 16'h0000) begin
        init_mask[address[2:0]] = 1'b1;
        init_cnt++;
      end
    end
  end

  function automatic logic [1:0] onehot(input int id);
    onehot = (id == 1) ? 2'b10 : 2'b01;
  endfunction

  // Response monitor: every RspValid pops the oldest expectation.
  always @(negedge CLK) begin : rsp_mon
    exp_t e;
    if (RspValid != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got RspValid=%b data=%h, want no response",
                 RspValid, RspRdData);
      end else begin
        e = sb.pop_front();
        if (RspValid !== onehot(e.id) || RspRdData !== e.data || RspErr !== e.err ||
            cyc != e.cyc + 3) begin
          errors++;
          $display("FAIL rsp: got valid=%b data=%h err=%b cyc=%0d, want valid=%b data=%h err=%b cyc=%0d",
                   RspValid, RspRdData, RspErr, cyc, onehot(e.id), e.data, e.err, e.cyc + 3);
        end
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reset, check reset values, then check the clear sequence and its length.
  task automatic reset_and_init();
    int n = 0;
    bit saw_ready = 1'b0;
    RST = 1'b1;
    ReqValid = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ReqReady", ReqReady, 0);
    check("rst_RspValid", RspValid, 0);
    check("rst_RspRdData", RspRdData, 0);
    check("rst_RspErr", RspErr, 0);
    check("rst_InitDone", InitDone, 0);
    check("rst_WrEn_RdEn", {WrEn, RdEn}, 0);
    check("rst_address", address, 0);
    check("rst_WrData", WrData, 0);
    ReqValid = 2'b11;
    RST = 1'b0;
    while (!InitDone && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (!InitDone && ReqReady != 2'b00) saw_ready = 1'b1;
    end
    ReqValid = '0;
    check("init_cycles", n, 8);
    check("no_ready_during_init", saw_ready, 0);
    @(posedge CLK);
    #1;
    check("init_mask", init_mask, 8'hFF);
    check("init_writes", init_cnt, 8);
  endtask

  // Present one request and hold it until accepted; expects are pushed on acceptance.
  task automatic do_req(input int id, input bit we, input logic [3:0] a, input logic [15:0] d,
                        input bit exp_err, input logic [15:0] exp_data, input bit want_rsp);
    bit got = 1'b0;
    exp_t e;
    ReqWrEn[id] = we;
    ReqAddr[id*4 +: 4] = a;
    ReqWrData[id*16 +: 16] = d;
    ReqValid[id] = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CLK);
      if (ReqReady[id]) got = 1'b1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: requester %0d got no ReqReady, want accept within 20 cycles", id);
    end else if (want_rsp) begin
      e.id = id;
      e.err = exp_err;
      e.data = exp_data;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    ReqValid[id] = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin
    int c0;
    exp_t e;
    reset_and_init();

    // Clear: every location reads back INIT_VALUE.
    for (int a = 0; a < 8; a++) do_req(0, 1'b0, 4'(a), 16'h0, 1'b0, 16'h0000, 1'b1);
    drain();

    // Write/read across requesters.
    do_req(0, 1'b1, 4'd3, 16'hAC31, 1'b0, 16'h0000, 1'b1);
    do_req(1, 1'b1, 4'd6, 16'h0025, 1'b0, 16'h0000, 1'b1);
    do_req(1, 1'b0, 4'd3, 16'h0000, 1'b0, 16'hAC31, 1'b1);
    do_req(0, 1'b0, 4'd6, 16'h0000, 1'b0, 16'h0025, 1'b1);
    drain();

    // Out of range: error responses, RAM untouched.
    c0 = ram_cmds;
    do_req(1, 1'b1, 4'b1001, 16'h1031, 1'b1, 16'h0000, 1'b1);
    do_req(1, 1'b0, 4'd9, 16'h0000, 1'b1, 16'h0000, 1'b1);
    drain();
    check("oor_ram_cmds", ram_cmds - c0, 0);

    // Back-to-back write then read of the same address.
    do_req(0, 1'b1, 4'd1, 16'h1031, 1'b0, 16'h0000, 1'b1);
    do_req(0, 1'b0, 4'd1, 16'h0000, 1'b0, 16'h1031, 1'b1);
    drain();
    check("sb_drained_1", sb.size(), 0);

    // Contention from rr=0: strict alternation.
    reset_and_init();
    ReqWrEn = 2'b00;
    ReqAddr = {4'd5, 4'd2};
    ReqValid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("contention_grant", ReqReady, (k % 2 == 1) ? 2'b10 : 2'b01);
      e.id = k % 2;
      e.err = 1'b0;
      e.data = 16'h0000;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    ReqValid = '0;
    drain();
    check("sb_drained_2", sb.size(), 0);

    // Reset one cycle after a read is accepted: its response must never appear.
    do_req(0, 1'b0, 4'd3, 16'h0000, 1'b0, 16'h0000, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_InitDone", InitDone, 0);
    check("midrst_RspValid", RspValid, 0);
    reset_and_init();
    drain();
    check("sb_drained_3", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller for the single-port RAM (write enable, read enable, address, write data, registered read data). After reset it clears every RAM location. It then shares the RAM between two requesters through a valid/ready request handshake, using round-robin arbitration, and returns per-requester responses in order. It sits directly in front of the RAM, drives all of its control and data inputs, and is the only master of it.

## Interface
- ADDR_WIDTH, 4, RAM address width
- MEM_DEPTH, 8, number of implemented RAM words; addresses ≥ MEM_DEPTH are out of range
- MEM_WIDTH, 16, data width
- INIT_VALUE, 0, word written to every location during the post-reset clear
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- ReqValid  in  2  per-requester request valid (bit i = requester i)
- ReqReady  out  2  per-requester request accepted this cycle
- ReqWrEn  in  2  1 = write, 0 = read
- ReqAddr  in  2*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- ReqWrData  in  2*MEM_WIDTH  requester i at bits [i*MEM_WIDTH +: MEM_WIDTH]
- RspValid  out  2  one-cycle response strobe per requester
- RspRdData  out  MEM_WIDTH  read data; 0 for writes and errors
- RspErr  out  1  response is for an out-of-range address
- InitDone  out  1  clear finished; arbitration active
- WrEn, RdEn  out  1 each  to RAM
- address  out  ADDR_WIDTH  to RAM
- WrData  out  MEM_WIDTH  to RAM
- RdData  in  MEM_WIDTH  from RAM; valid the cycle after RdEn is sampled

## Operation
- FSM states: INIT, ARB. Reset enters INIT.
- **INIT**
  - A counter runs 0..MEM_DEPTH-1.
  - Each cycle: WrEn=1, RdEn=0, address=counter, WrData=INIT_VALUE.
  - ReqReady=00.
  - After address MEM_DEPTH-1 is issued: go to ARB and set InitDone=1.
- **ARB**
  - Arbitration is combinational from ReqValid and the round-robin pointer (rr).
  - One valid requester: that requester is granted.
  - Both valid: requester rr is granted.
  - After any grant, rr is set to the other requester.
  - ReqReady is one-hot on the granted requester, 00 if none.
  - A requester holds valid, WrEn, address and data stable until it sees ReqReady.
- **Accepted in-range request**
  - Registered into the RAM outputs at the accepting edge.
  - Write: WrEn=1, RdEn=0. Read: WrEn=0, RdEn=1.
  - A 2-stage tag pipeline carries {requester id, err, is_read}.
- **Accepted out-of-range request** (address ≥ MEM_DEPTH)
  - Not forwarded: WrEn=RdEn=0.
  - Same tag-pipeline slot with err=1.
  - Response has RspErr=1 and RspRdData=0.
- **Responses**
  - Every accepted request, read or write, produces exactly one RspValid pulse to its requester.
  - Responses are in acceptance order.
- No accepted request in a cycle: WrEn=RdEn=0 next cycle; address and WrData hold.

## Timing
- **Reset values:**
  - ReqReady=00, RspValid=00, RspRdData=0, RspErr=0, InitDone=0.
  - WrEn=0, RdEn=0, address=0, WrData=0.
  - rr=0, INIT counter=0.
- **INIT:** lasts MEM_DEPTH cycles after RST deasserts. The first ReqReady can be high in cycle MEM_DEPTH.
- **Latency:**
  - Request accepted at edge E0.
  - RAM command driven E0→E1; RAM samples at E1.
  - RdData captured at E2.
  - RspValid is high for the single cycle following E2, a fixed 2 cycles after acceptance.
- **Throughput:** one request per cycle, with no bubbles under back-to-back grants.
- **Write then read, same address, consecutive cycles:** the read returns the new data, because RAM commands are issued in order.
- **Both requesters valid continuously:** grants strictly alternate 0,1,0,1 starting from the current rr.
- **RST mid-operation:**
  - Outputs return to reset values immediately.
  - In-flight tags are discarded; no RspValid is issued for them.
  - INIT restarts from address 0.

## Structure
- Package ram_ctrl_pkg holds:
  - the state enum (INIT, ARB);
  - default constants for ADDR_WIDTH, MEM_DEPTH and MEM_WIDTH;
  - NUM_REQ=2;
  - the tag struct {id, err, is_read}.
- Sub-module rr_arbiter2: combinational 2-way grant plus the registered rr pointer, with ports CLK, RST, req[1:0], grant[1:0].
- The top level holds the FSM, INIT counter, RAM output registers and the 2-stage tag pipeline.

## Test plan
- **Clear:**
  - Release RST, wait for InitDone.
  - Requester 0 reads addresses 0..7.
  - Required: every response has RspRdData=16'h0000, RspErr=0, RspValid=01, arriving 2 cycles after ReqReady.
- **Write/read:**
  - Requester 0 writes 16'hAC31 to address 3.
  - Requester 1 writes 16'h0025 to address 6.
  - Requester 1 reads address 3, then requester 0 reads address 6.
  - Required: responses of 16'hAC31 on RspValid=10, then 16'h0025 on RspValid=01.
- **Contention:**
  - Both requesters hold ReqValid for 6 cycles from reset-state rr=0.
  - Required: grants 0,1,0,1,0,1 and responses in the same order.
- **Out of range:**
  - Requester 1 writes 16'h1031 to address 4'b1001, then reads address 9.
  - Required: the RAM never sees WrEn or RdEn, RspErr=1 on both responses, RspRdData=0.
- **Back-to-back:**
  - Requester 0 writes 16'h1031 to address 1, and reads address 1 in the next cycle.
  - Required: the read returns 16'h1031.
- **Reset mid-flight:**
  - Assert RST one cycle after a read is accepted.
  - Required: no RspValid for that read, InitDone=0, and INIT rewrites addresses 0..7.
